// File: rtl/softmax_row_buffer_pkg.sv
// ---------------------------------------------------------------------------
// softmax_row_buffer_pkg
// Shared types and derived sizes for the softmax row buffer.
//   elem_t : one signed softmax element
//   beat_t : PACK elements packed into one output beat, lane 0 in the LSBs
//   BEATS  : output beats per row
//   BEAT_W : width of the beat index
//   COL_W  : width of the in-row column index
// ---------------------------------------------------------------------------
package softmax_row_buffer_pkg;

  localparam int DEF_D_W          = 8;
  localparam int DEF_N            = 32;
  localparam int DEF_PACK         = 4;
  localparam int DEF_MATRIXSIZE_W = 16;

  localparam int BEATS  = DEF_N / DEF_PACK;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int COL_W  = (DEF_N > 1) ? $clog2(DEF_N) : 1;

  typedef logic signed [DEF_D_W-1:0] elem_t;
  typedef elem_t [DEF_PACK-1:0]      beat_t;

endpackage

// File: rtl/softmax_row_buffer_row_bank.sv
// ---------------------------------------------------------------------------
// softmax_row_buffer_row_bank
// One N-element row of storage with a full flag.
//   clk, rst_n   : clock, asynchronous active-low reset (flag only)
//   i_wr_en      : write i_wr_data at column i_wr_col
//   i_set_full   : mark the bank full (row completed)
//   i_clr_full   : mark the bank empty (row drained)
//   i_beat       : beat index for the combinational read port
//   o_rd_data    : PACK elements starting at i_beat*PACK, lane 0 in LSBs
//   o_full       : bank holds a complete row
// ---------------------------------------------------------------------------
module softmax_row_buffer_row_bank
  import softmax_row_buffer_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_en,
  input  logic [COL_W-1:0]             i_wr_col,
  input  logic [DEF_D_W-1:0]           i_wr_data,
  input  logic                         i_set_full,
  input  logic                         i_clr_full,
  input  logic [BEAT_W-1:0]            i_beat,
  output logic [DEF_PACK*DEF_D_W-1:0]  o_rd_data,
  output logic                         o_full
);

  elem_t r_mem [DEF_N];
  logic  r_full;
  beat_t w_rd;

  // NOTE: the data array has no reset; the full flag alone says whether it is
  // meaningful, and leaving it out keeps the storage as plain flops/RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_col] <= i_wr_data;
  end

  // NOTE: every path assigns r_full or holds it inside a clocked block, so no
  // latch can appear; set and clear never target the same bank at one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_full <= 1'b0;
    else if (i_set_full) r_full <= 1'b1;
    else if (i_clr_full) r_full <= 1'b0;
  end

  // NOTE: always_comb gives w_rd a default first so no latch is inferred.
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < DEF_PACK; k++) begin
      w_rd[k] = r_mem[COL_W'(int'(i_beat) * DEF_PACK + k)];
    end
  end

  assign o_rd_data = w_rd;
  assign o_full    = r_full;

endmodule

// File: rtl/softmax_row_buffer.sv
// ---------------------------------------------------------------------------
// softmax_row_buffer
// Captures the int8 softmax stream row by row into two banks (ping-pong) and
// replays each completed row as PACK-element beats with valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : input element strobe (no backpressure)
//   in_data    : signed element, row-major
//   out_valid  : a completed row is being offered
//   out_ready  : downstream accepts the current beat
//   out_data   : packed beat, element k in bits [k*D_W +: D_W]
//   out_last   : last beat of the row
//   out_row    : row index being emitted, 0..N-1
//   done       : one-cycle pulse after the last beat of row N-1 is accepted
//   overflow   : sticky, an input element was dropped (both banks full)
// ---------------------------------------------------------------------------
module softmax_row_buffer
  import softmax_row_buffer_pkg::*;
#(
  parameter int D_W          = DEF_D_W,
  parameter int N            = DEF_N,
  parameter int PACK         = DEF_PACK,
  parameter int MATRIXSIZE_W = DEF_MATRIXSIZE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [D_W-1:0]          in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PACK*D_W-1:0]     out_data,
  output logic                    out_last,
  output logic [MATRIXSIZE_W-1:0] out_row,
  output logic                    done,
  output logic                    overflow
);

  if (N % PACK != 0) begin : g_bad_pack
    $error("softmax_row_buffer: N must be a multiple of PACK");
  end
  // Storage types come from the package, so the geometry is fixed there.
  if (D_W != DEF_D_W || N != DEF_N || PACK != DEF_PACK) begin : g_bad_geom
    $error("softmax_row_buffer: D_W/N/PACK must match softmax_row_buffer_pkg");
  end

  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic [COL_W-1:0]        r_wr_col;
  logic [BEAT_W-1:0]       r_beat;
  logic [MATRIXSIZE_W-1:0] r_out_row;
  logic                    r_done;
  logic                    r_overflow;

  logic [1:0]                 w_full;
  logic [1:0][PACK*D_W-1:0]   w_rd_data;
  logic                       w_wr_en;
  logic                       w_last_col;
  logic                       w_last_beat;
  logic                       w_hs;
  logic                       w_release;

  // Drop decision uses the pre-edge full flag of the target bank.
  assign w_wr_en     = in_valid & ~w_full[r_wr_bank];
  assign w_last_col  = (r_wr_col == COL_W'(N - 1));
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_hs        = out_valid & out_ready;
  assign w_release   = w_hs & w_last_beat;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    softmax_row_buffer_row_bank u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_wr_en & (r_wr_bank == 1'(b))),
      .i_wr_col   (r_wr_col),
      .i_wr_data  (in_data),
      .i_set_full (w_wr_en & w_last_col & (r_wr_bank == 1'(b))),
      .i_clr_full (w_release & (r_rd_bank == 1'(b))),
      .i_beat     (r_beat),
      .o_rd_data  (w_rd_data[b]),
      .o_full     (w_full[b])
    );
  end

  // out_valid is the registered full flag: no path from in_valid.
  assign out_valid = w_full[r_rd_bank];
  assign out_data  = w_rd_data[r_rd_bank];
  assign out_last  = out_valid & w_last_beat;
  assign out_row   = r_out_row;
  assign done      = r_done;
  assign overflow  = r_overflow;

  // NOTE: state updates use non-blocking assignments so every term on the
  // right-hand side is the pre-edge value, which the simultaneous
  // write/release rules rely on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_col   <= '0;
      r_beat     <= '0;
      r_out_row  <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (w_last_col) begin
          r_wr_col  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_col  <= r_wr_col + 1'b1;
        end
      end
      if (in_valid && !w_wr_en) r_overflow <= 1'b1;

      if (w_hs) begin
        if (w_last_beat) begin
          r_beat    <= '0;
          r_rd_bank <= ~r_rd_bank;
          r_out_row <= (r_out_row == MATRIXSIZE_W'(N - 1)) ? '0
                                                           : r_out_row + MATRIXSIZE_W'(1);
        end else begin
          r_beat    <= r_beat + 1'b1;
        end
      end
      r_done <= w_release & (r_out_row == MATRIXSIZE_W'(N - 1));
    end
  end

endmodule

// File: tb/tb_softmax_row_buffer.sv
module tb_softmax_row_buffer;

  localparam int D_W = 8;
  localparam int N   = 32;
  localparam int PACK = 4;
  localparam int NB  = N / PACK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [D_W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PACK*D_W-1:0] out_data;
  logic             out_last;
  logic [15:0]      out_row;
  logic             done;
  logic             overflow;

  softmax_row_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_row   (out_row),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;

  // Reference model: a FIFO of completed rows (at most two can be held),
  // the partially collected row, and a read position within the head row.
  typedef logic [D_W-1:0] row_t [N];
  row_t m_q[$];
  row_t m_part;
  int   m_n;
  int   m_beat;
  int   m_row;
  bit   m_done;
  bit   m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_n = 0; m_beat = 0; m_row = 0; m_done = 0; m_ovf = 0;
  endtask

  function automatic logic [31:0] exp_beat();
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < PACK; k++) r[k*D_W +: D_W] = m_q[0][m_beat*PACK + k];
    return r;
  endfunction

  // One clock edge of the model, using the state before the edge.
  task automatic model_step(input logic v, input logic [7:0] d, input logic rdy);
    bit hs, wr;
    hs = (m_q.size() > 0) && rdy;
    wr = v && (m_q.size() < 2);
    if (v && !wr) m_ovf = 1;
    m_done = 0;
    if (hs) begin
      if (m_beat == NB - 1) begin
        void'(m_q.pop_front());
        m_beat = 0;
        m_done = (m_row == N - 1);
        m_row  = (m_row + 1) % N;
      end else begin
        m_beat++;
      end
    end
    if (wr) begin
      m_part[m_n] = d;
      m_n++;
      if (m_n == N) begin
        m_q.push_back(m_part);
        m_n = 0;
      end
    end
  endtask

  task automatic compare();
    bit v;
    v = (m_q.size() > 0);
    check("out_valid", 64'(out_valid), 64'(v));
    if (v) begin
      check("out_data", 64'(out_data), 64'(exp_beat()));
      check("out_last", 64'(out_last), 64'(m_beat == NB - 1));
    end else begin
      check("out_last_idle", 64'(out_last), 64'd0);
    end
    check("out_row", 64'(out_row), 64'(m_row));
    check("done", 64'(done), 64'(m_done));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (done === 1'b1) n_done++;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy);
    in_valid = v; in_data = d; out_ready = rdy;
    @(posedge clk);
    model_step(v, d, rdy);
    #1;
    compare();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic send_rand_row(input logic rdy);
    for (int i = 0; i < N; i++) cycle(1'b1, 8'($urandom_range(255)), rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] first4 [PACK];
    logic [31:0] exp_first;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #12;
    // Reset state
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last",  64'(out_last),  64'd0);
    check("rst_row",   64'(out_row),   64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_ovf",   64'(overflow),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic row: elements 0..31, out_ready high
    for (int i = 0; i < N; i++) cycle(1'b1, 8'(i), 1'b1);
    check("basic_beat0", 64'(out_data), 64'h03020100);
    idle(7, 1'b1);
    check("basic_beat7", 64'(out_data), 64'h1F1E1D1C);
    check("basic_last7", 64'(out_last), 64'd1);
    idle(3, 1'b1);

    // Backpressure: same pattern, hold ready low for 10 cycles
    for (int i = 0; i < N; i++) cycle(1'b1, 8'(i), 1'b0);
    idle(10, 1'b0);
    check("bp_hold_data", 64'(out_data), 64'h03020100);
    idle(NB + 2, 1'b1);

    // Ping-pong: rows 0 and 1 back to back after a fresh reset
    do_reset();
    send_rand_row(1'b1);
    for (int i = 0; i < N; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1);
    check("pp_beat0", 64'(out_data), 64'h83828180);
    check("pp_row1",  64'(out_row),  64'd1);
    idle(NB + 2, 1'b1);

    // Overflow: 65 elements with ready low; the 65th is dropped
    for (int i = 0; i < 2 * N + 1; i++) cycle(1'b1, 8'($urandom_range(255)), 1'b0);
    check("ovf_set", 64'(overflow), 64'd1);
    idle(2 * NB + 4, 1'b1);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_no_partial", 64'(out_valid), 64'd0);

    // Async reset mid-row with a full row pending
    send_rand_row(1'b0);
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'($urandom_range(255)), 1'b0);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_last",  64'(out_last),  64'd0);
    check("arst_row",   64'(out_row),   64'd0);
    check("arst_ovf",   64'(overflow),  64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(2, 1'b0);
    for (int i = 0; i < N; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(255));
      if (i < PACK) first4[i] = d;
      cycle(1'b1, d, 1'b0);
    end
    for (int k = 0; k < PACK; k++) exp_first[k*D_W +: D_W] = first4[k];
    check("arst_new_beat0", 64'(out_data), 64'(exp_first));
    idle(NB + 2, 1'b1);

    // Head done: 32 rows from reset, done pulses once, out_row wraps to 0
    do_reset();
    n_done = 0;
    for (int r = 0; r < N; r++) send_rand_row(1'b1);
    idle(NB + 4, 1'b1);
    check("head_done_once", 64'(n_done), 64'd1);
    check("head_row_wrap",  64'(out_row), 64'd0);
    check("head_no_ovf",    64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
